numero_a_bcd: RTL
=================

Name: numero_a_bcd

Overview:
- Sequential binary-to-BCD converter (shift-add-3, "double dabble") sitting directly downstream of the Celsius/Fahrenheit number selector.
- Takes the selected 10-bit unsigned temperature value and produces four BCD digits (miles, centenas, decenas, unidades) for the 7-segment display driver.
- One shift per clock; start/busy/done handshake; results held stable between conversions.

Parameters:
- WIDTH, 10, binary input width. Supported range is 4..13, so the maximum value always fits in 4 BCD digits (9999).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  conversion request, sampled on the rising edge.
- numero  input  WIDTH  unsigned binary value, captured on the accepted start edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the digit outputs have been updated.
- miles  output  4  BCD thousands digit.
- centenas  output  4  BCD hundreds digit.
- decenas  output  4  BCD tens digit.
- unidades  output  4  BCD units digit.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge) forces: state=IDLE, busy=0, done=0, all digit outputs=4'h0, internal shift register and counter cleared. Reset overrides all other inputs, including mid-conversion.
- Internal state: shift register {bcd[15:0], bin[WIDTH-1:0]} plus an iteration counter sized for 0..WIDTH-1.
- FSM has two states, IDLE and CONV.
- IDLE:
  - On start=1: load bin<=numero, bcd<=0, cnt<=0, busy<=1, go to CONV.
  - On start=0: hold.
  - done is always driven 0 on the next edge unless it is being set.
- CONV, each edge:
  - Every BCD nibble >=5 gets +3, computed combinationally from the current register.
  - The adjusted {bcd,bin} is then shifted left by 1; cnt<=cnt+1.
- CONV, when cnt==WIDTH-1 (last shift):
  - Write the post-shift BCD nibbles into miles/centenas/decenas/unidades.
  - done<=1, busy<=0, go to IDLE.
- Latency: start accepted at edge k gives done=1 and new digits visible after edge k+WIDTH (10 cycles by default). done lasts exactly one cycle.
- start while busy=1 is ignored; numero is not re-sampled during a conversion.
- start=1 in the cycle where done=1 is accepted, because the FSM is already in IDLE, giving back-to-back conversions with no dead cycle.
- Digit outputs change only on the done-setting edge or on reset. They hold the previous result while busy.
- Boundaries:
  - numero=0 gives 0,0,0,0.
  - numero=2^WIDTH-1 (1023 by default) gives 1,0,2,3.
  - No overflow is possible within the supported WIDTH range.
- Reset asserted mid-conversion aborts it: no done pulse, digits return to 0.

Optional Feature:
- Macro: NUMERO_A_BCD_BLANK_EN.
- Defined: leading-zero blanking applied at digit-output write time.
  - Any leading zero digit (scanning miles to decenas) is output as 4'hF, which the display driver renders as blank.
  - unidades is never blanked.
  - Example: 7 gives F,F,F,7; 0 gives F,F,F,0.
  - Reset value becomes F,F,F,0.
- Undefined: raw BCD is always output, including leading zeros; reset value is 0,0,0,0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, digits 0,0,0,0; no conversion starts until rst_n=1.
- Single conversion: numero=1023, start pulse at edge k -> busy=1 for cycles k+1..k+10, done=1 only after edge k+10, digits 1,0,2,3 (blank build: same).
- Value set: 0, 9, 10, 99, 100, 999, 500 -> 0000, 0009, 0010, 0099, 0100, 0999, 0500; with BLANK_EN: FFF0, FFF9, FF10, FF99, F100, F999, F500.
- Start while busy: start numero=37, then at edge k+4 pulse start with numero=812 -> only one done, digits 0,0,3,7; busy is not extended.
- Back-to-back: start=1 held continuously, numero=255 then 256 changed on the done cycle -> done pulses every 11 cycles, giving 0255 then 0256.
- Reset mid-run: start numero=640, drop rst_n at edge k+5 -> no done pulse, digits 0000 (blank build F,F,F,0), FSM in IDLE; the next start converts normally.

Source files
------------

// File: rtl/numero_a_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one shift per clock, start/busy/done handshake.
// Define NUMERO_A_BCD_BLANK_EN to output leading-zero digits as 4'hF (blank on the display).
module numero_a_bcd #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] numero,
  output logic             busy,
  output logic             done,
  output logic [3:0]       miles,
  output logic [3:0]       centenas,
  output logic [3:0]       decenas,
  output logic [3:0]       unidades
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef NUMERO_A_BCD_BLANK_EN
  localparam logic [15:0] RESET_DIGITS = 16'hFFF0;
`else
  localparam logic [15:0] RESET_DIGITS = 16'h0000;
`endif

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state;
  logic [15:0]      bcd;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0]    cnt;
  logic [15:0]      digits;

  logic [15:0]       bcd_adj;
  logic [WIDTH+15:0] shifted;

  // Scanning from the thousands digit, every leading zero above the units becomes blank.
  function automatic logic [15:0] format_digits(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef NUMERO_A_BCD_BLANK_EN
    if (d[15:12] == 4'h0) begin
      r[15:12] = 4'hF;
      if (d[11:8] == 4'h0) begin
        r[11:8] = 4'hF;
        if (d[7:4] == 4'h0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      bcd    <= '0;
      bin    <= '0;
      cnt    <= '0;
      digits <= RESET_DIGITS;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin   <= numero;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd <= shifted[WIDTH+15:WIDTH];
          bin <= shifted[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            digits <= format_digits(shifted[WIDTH+15:WIDTH]);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miles    = digits[15:12];
  assign centenas = digits[11:8];
  assign decenas  = digits[7:4];
  assign unidades = digits[3:0];

endmodule
